// File: rtl/alu_seq.sv
// Multi-cycle ALU with a carry register and compare flags; shift, multiply and pattern-count ops iterate one step per cycle.
// Latency: out_valid_o rises N+1 edges after the accept edge (N = 0, k, WIDTH or WIDTH-PAT_W+1 depending on op).
// Backpressure: in_ready_o is high only in IDLE; DONE holds result/carry/flags until out_ready_i is seen.
module alu_seq #(
   parameter int WIDTH = 8,
   parameter int PAT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [3:0]       op_i,
   input  logic [WIDTH-1:0] rs_i,
   input  logic [WIDTH-1:0] rt_i,
   input  logic [WIDTH-1:0] cnt_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] result_o,
   output logic             carry_o,
   output logic [2:0]       flags_o
);

   // shift amount bits and iteration counter width (counter must reach WIDTH)
   localparam int SHW = $clog2(WIDTH);
   localparam int CW  = $clog2(WIDTH + 1);

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_ADDC = 4'd1;
   localparam logic [3:0] OP_SUB  = 4'd2;
   localparam logic [3:0] OP_CMP  = 4'd3;
   localparam logic [3:0] OP_SLL  = 4'd4;
   localparam logic [3:0] OP_SLR  = 4'd5;
   localparam logic [3:0] OP_ABSD = 4'd6;
   localparam logic [3:0] OP_MUL  = 4'd7;
   localparam logic [3:0] OP_PAR  = 4'd8;

   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

   state_t             state_q;
   logic               in_ready_q;
   logic               out_valid_q;
   logic [WIDTH-1:0]   result_q;
   logic               carry_q;
   logic [2:0]         flags_q;

   // captured operands
   logic [3:0]         op_q;
   logic [WIDTH-1:0]   rs_q;
   logic [WIDTH-1:0]   rt_q;
   logic [WIDTH-1:0]   cnt_q;

   // iteration state: sh_q is the shift value (SLL/SLR), multiplier (MUL) or window source (PARCMP);
   // acc_q is the product (MUL) or match count (PARCMP); sc_q is the last bit shifted out
   logic [WIDTH-1:0]   sh_q;
   logic               sc_q;
   logic [2*WIDTH-1:0] acc_q;
   logic [2*WIDTH-1:0] mcand_q;
   logic [CW-1:0]      iter_q;
   logic [CW-1:0]      n_q;

   logic [CW-1:0]      n_nx;
   logic [WIDTH-1:0]   fin_result;
   logic               fin_carry;
   logic [2:0]         fin_flags;
   logic [WIDTH:0]     add_w;
   logic [WIDTH:0]     diff_w;
   logic [WIDTH:0]     absd_w;

   assign in_ready_o  = in_ready_q;
   assign out_valid_o = out_valid_q;
   assign result_o    = result_q;
   assign carry_o     = carry_q;
   assign flags_o     = flags_q;

   // iteration count for the op being accepted
   always_comb begin
      n_nx = '0;
      case (op_i)
         OP_SLL, OP_SLR: n_nx = CW'(rt_i[SHW-1:0]);
         OP_MUL:         n_nx = CW'(WIDTH);
         OP_PAR:         n_nx = CW'(WIDTH - PAT_W + 1);
         default:        n_nx = '0;
      endcase
   end

   // final result/carry/flags written on entry to DONE; ops that do not own carry or flags keep them
   always_comb begin
      fin_result = '0;
      fin_carry  = carry_q;
      fin_flags  = flags_q;
      add_w      = '0;
      diff_w     = '0;
      absd_w     = '0;
      case (op_q)
         OP_ADD: begin
            add_w      = {1'b0, rs_q} + {1'b0, rt_q};
            fin_result = add_w[WIDTH-1:0];
            fin_carry  = add_w[WIDTH];
         end
         OP_ADDC: begin
            add_w      = {1'b0, rs_q} + {1'b0, rt_q} + {{WIDTH{1'b0}}, carry_q};
            fin_result = add_w[WIDTH-1:0];
            fin_carry  = add_w[WIDTH];
         end
         OP_SUB: begin
            fin_result = rs_q - rt_q;
            fin_carry  = (rs_q < rt_q);
         end
         OP_CMP: begin
            fin_result = '0;
            fin_flags  = {rs_q < rt_q, rs_q > rt_q, rs_q == rt_q};
         end
         OP_SLL, OP_SLR: begin
            fin_result = sh_q;
            fin_carry  = sc_q;
         end
         OP_ABSD: begin
            // sign-extend by one bit so the difference of two signed operands cannot overflow
            diff_w     = {rs_q[WIDTH-1], rs_q} - {rt_q[WIDTH-1], rt_q};
            absd_w     = diff_w[WIDTH] ? ((WIDTH+1)'(0) - diff_w) : diff_w;
            fin_result = absd_w[WIDTH-1:0];
         end
         OP_MUL: begin
            fin_result = acc_q[WIDTH-1:0];
            fin_carry  = |acc_q[2*WIDTH-1:WIDTH];
         end
         OP_PAR: begin
            fin_result = cnt_q + acc_q[WIDTH-1:0];
         end
         default: fin_result = '0;
      endcase
   end

   // control FSM with registered outputs and the per-iteration datapath
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         carry_q     <= 1'b0;
         flags_q     <= '0;
         op_q        <= '0;
         rs_q        <= '0;
         rt_q        <= '0;
         cnt_q       <= '0;
         sh_q        <= '0;
         sc_q        <= 1'b0;
         acc_q       <= '0;
         mcand_q     <= '0;
         iter_q      <= '0;
         n_q         <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid_i) begin
                  op_q       <= op_i;
                  rs_q       <= rs_i;
                  rt_q       <= rt_i;
                  cnt_q      <= cnt_i;
                  sh_q       <= (op_i == OP_MUL || op_i == OP_PAR) ? rt_i : rs_i;
                  sc_q       <= 1'b0;
                  acc_q      <= '0;
                  mcand_q    <= {{WIDTH{1'b0}}, rs_i};
                  iter_q     <= '0;
                  n_q        <= n_nx;
                  in_ready_q <= 1'b0;
                  state_q    <= EXEC;
               end
            end
            EXEC: begin
               if (iter_q == n_q) begin
                  result_q    <= fin_result;
                  carry_q     <= fin_carry;
                  flags_q     <= fin_flags;
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end else begin
                  iter_q <= iter_q + {{(CW-1){1'b0}}, 1'b1};
                  case (op_q)
                     OP_SLL: begin
                        sc_q <= sh_q[WIDTH-1];
                        sh_q <= sh_q << 1;
                     end
                     OP_SLR: begin
                        sc_q <= sh_q[0];
                        sh_q <= sh_q >> 1;
                     end
                     OP_MUL: begin
                        if (sh_q[0]) acc_q <= acc_q + mcand_q;
                        mcand_q <= mcand_q << 1;
                        sh_q    <= sh_q >> 1;
                     end
                     OP_PAR: begin
                        // top PAT_W bits are window i = WIDTH-PAT_W-iter, walking down to 0
                        if (sh_q[WIDTH-1 -: PAT_W] == rs_q[PAT_W-1:0])
                           acc_q <= acc_q + {{(2*WIDTH-1){1'b0}}, 1'b1};
                        sh_q <= sh_q << 1;
                     end
                     default: sh_q <= sh_q;
                  endcase
               end
            end
            DONE: begin
               if (out_ready_i) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: begin
               state_q     <= IDLE;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq at WIDTH=8, PAT_W=4.
// Checks result, carry, flags and latency per op, DONE-state backpressure and mid-op reset.
// Inputs change #1 after the rising edge; outputs are sampled #1 after the rising edge.
module tb_alu_seq;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       in_valid_i = 1'b0;
   logic       in_ready_o;
   logic [3:0] op_i = '0;
   logic [7:0] rs_i = '0;
   logic [7:0] rt_i = '0;
   logic [7:0] cnt_i = '0;
   logic       out_valid_o;
   logic       out_ready_i = 1'b0;
   logic [7:0] result_o;
   logic       carry_o;
   logic [2:0] flags_o;

   int total = 0;
   int bad = 0;

   alu_seq #(.WIDTH(8), .PAT_W(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .op_i        (op_i),
      .rs_i        (rs_i),
      .rt_i        (rt_i),
      .cnt_i       (cnt_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .result_o    (result_o),
      .carry_o     (carry_o),
      .flags_o     (flags_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // issue one op, scramble inputs after accept, then wait for out_valid_o
   task automatic issue(input logic [3:0] op, input logic [7:0] rs, input logic [7:0] rt,
                        input logic [7:0] cnt, output int lat);
      op_i = op; rs_i = rs; rt_i = rt; cnt_i = cnt; in_valid_i = 1'b1;
      @(posedge clk); #1;
      in_valid_i = 1'b0;
      op_i = 4'hF; rs_i = 8'h5A; rt_i = 8'hC3; cnt_i = 8'h77;
      lat = 0;
      for (int e = 1; e <= 20; e++) begin
         if (out_valid_o) break;
         @(posedge clk); #1;
         if (out_valid_o) lat = e;
      end
   endtask

   // drain the result and confirm the block is back in IDLE
   task automatic drain(input string tag);
      out_ready_i = 1'b1;
      @(posedge clk); #1;
      out_ready_i = 1'b0;
      chk({tag, ".valid_drop"}, {31'd0, out_valid_o}, 32'd0);
      chk({tag, ".ready_back"}, {31'd0, in_ready_o}, 32'd1);
   endtask

   task automatic run_op(input string tag, input logic [3:0] op, input logic [7:0] rs,
                         input logic [7:0] rt, input logic [7:0] cnt, input logic [7:0] exp_res,
                         input logic exp_c, input logic [2:0] exp_f, input int exp_lat);
      int lat;
      issue(op, rs, rt, cnt, lat);
      chk({tag, ".lat"}, lat, exp_lat);
      chk({tag, ".result"}, {24'd0, result_o}, {24'd0, exp_res});
      chk({tag, ".carry"}, {31'd0, carry_o}, {31'd0, exp_c});
      chk({tag, ".flags"}, {29'd0, flags_o}, {29'd0, exp_f});
      drain(tag);
   endtask

   initial begin
      int lat;
      repeat (3) @(posedge clk);
      #1;
      chk("rst.valid", {31'd0, out_valid_o}, 32'd0);
      chk("rst.ready", {31'd0, in_ready_o}, 32'd1);
      chk("rst.result", {24'd0, result_o}, 32'd0);
      chk("rst.carry", {31'd0, carry_o}, 32'd0);
      chk("rst.flags", {29'd0, flags_o}, 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;

      //      tag       op     rs     rt     cnt    result carry flags lat
      run_op("add",    4'd0, 8'hF0, 8'h20, 8'h00, 8'h10, 1'b1, 3'b000, 1);
      run_op("addc",   4'd1, 8'h01, 8'h01, 8'h00, 8'h03, 1'b0, 3'b000, 1);
      run_op("sll3",   4'd4, 8'h81, 8'h03, 8'h00, 8'h08, 1'b0, 3'b000, 4);
      run_op("slr0",   4'd5, 8'h81, 8'h00, 8'h00, 8'h81, 1'b0, 3'b000, 1);
      run_op("slr2",   4'd5, 8'h83, 8'hFA, 8'h00, 8'h20, 1'b1, 3'b000, 3);
      run_op("mul1",   4'd7, 8'h0F, 8'h11, 8'h00, 8'hFF, 1'b0, 3'b000, 9);
      run_op("mul2",   4'd7, 8'h10, 8'h10, 8'h00, 8'h00, 1'b1, 3'b000, 9);
      run_op("parcmp", 4'd8, 8'h05, 8'hAA, 8'h03, 8'h05, 1'b1, 3'b000, 6);
      run_op("absd",   4'd6, 8'h80, 8'h7F, 8'h00, 8'hFF, 1'b1, 3'b000, 1);
      run_op("cmp_lt", 4'd3, 8'h10, 8'h20, 8'h00, 8'h00, 1'b1, 3'b100, 1);
      run_op("illegal",4'd9, 8'h12, 8'h34, 8'h00, 8'h00, 1'b1, 3'b100, 1);
      run_op("sub_bw", 4'd2, 8'h05, 8'h07, 8'h00, 8'hFE, 1'b1, 3'b100, 1);
      run_op("sub_ok", 4'd2, 8'h07, 8'h05, 8'h00, 8'h02, 1'b0, 3'b100, 1);
      run_op("cmp_gt", 4'd3, 8'h30, 8'h20, 8'h00, 8'h00, 1'b0, 3'b010, 1);
      run_op("cmp_eq", 4'd3, 8'h20, 8'h20, 8'h00, 8'h00, 1'b0, 3'b001, 1);

      // backpressure: hold DONE for 5 cycles while pulsing in_valid_i
      issue(4'd0, 8'hFF, 8'h02, 8'h00, lat);
      chk("bp.lat", lat, 1);
      for (int c = 0; c < 5; c++) begin
         op_i = 4'd0; rs_i = 8'h01; rt_i = 8'h01; in_valid_i = (c % 2) == 0;
         @(posedge clk); #1;
         in_valid_i = 1'b0;
         chk("bp.valid", {31'd0, out_valid_o}, 32'd1);
         chk("bp.ready", {31'd0, in_ready_o}, 32'd0);
         chk("bp.result", {24'd0, result_o}, 32'h01);
         chk("bp.carry", {31'd0, carry_o}, 32'd1);
         chk("bp.flags", {29'd0, flags_o}, 32'b001);
      end
      drain("bp");
      // an ignored pulse must not have started a hidden op
      @(posedge clk); #1;
      chk("bp.idle_valid", {31'd0, out_valid_o}, 32'd0);

      // reset during iteration 4 of MUL aborts the op
      op_i = 4'd7; rs_i = 8'h10; rt_i = 8'h10; in_valid_i = 1'b1;
      @(posedge clk); #1;
      in_valid_i = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      chk("rstmid.valid", {31'd0, out_valid_o}, 32'd0);
      chk("rstmid.ready", {31'd0, in_ready_o}, 32'd1);
      chk("rstmid.carry", {31'd0, carry_o}, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      chk("rstmid.no_result", {31'd0, out_valid_o}, 32'd0);
      run_op("add_after", 4'd0, 8'h01, 8'h01, 8'h00, 8'h02, 1'b0, 3'b000, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // global watchdog so the run always ends
   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "timeout");
   end

endmodule
